// File: rtl/flow_writer_if.sv
// flow_writer_if - request, memory-port and hash-unit signals of the flow writer.
// The writer drives the master side; the control path, table memory and the
// shared hash unit sit on the slave side.

`ifndef QUAD_BUS
`define QUAD_BUS 63:0
`endif
`ifndef BYTE_BUS
`define BYTE_BUS 7:0
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 15:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef HASH_BUS
`define HASH_BUS 7:0
`endif
`ifndef MAX_VAL_LEN
`define MAX_VAL_LEN 12
`endif

interface flow_writer_if;
  // request side
  logic                                  start_i;
  logic [`QUAD_BUS]                      key_i;
  logic [5:0]                            key_len_i;
  logic [`MAX_VAL_LEN-1:0][`BYTE_BUS]    flow_val_i;
  logic [5:0]                            val_len_i;
  logic                                  ready_o;
  logic                                  error_o;
  logic                                  collision_o;

  // table memory port
  logic                                  mem_ce_o;
  logic                                  mem_we_o;
  logic [`ADDR_BUS]                      mem_addr_o;
  logic [3:0]                            mem_width_o;
  logic [`DATA_BUS]                      mem_data_o;
  logic [`DATA_BUS]                      mem_data_i;

  // shared hash unit
  logic                                  hash_start;
  logic [`QUAD_BUS]                      hash_key;
  logic [`HASH_BUS]                      hash_val;
  logic                                  hash_ready;

  modport master (
    input  start_i, key_i, key_len_i, flow_val_i, val_len_i,
    input  mem_data_i, hash_val, hash_ready,
    output ready_o, error_o, collision_o,
    output mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
    output hash_start, hash_key
  );

  modport slave (
    output start_i, key_i, key_len_i, flow_val_i, val_len_i,
    output mem_data_i, hash_val, hash_ready,
    input  ready_o, error_o, collision_o,
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
    input  hash_start, hash_key
  );
endinterface

// File: rtl/flow_writer.sv
// flow_writer - installs one exact-match flow entry (key bytes then value
// bytes) into the byte-addressed flow table at
// LOGIC_START_ADDR + hash(key)*LOGIC_ENTRY_LEN, one byte per cycle.
// Optional feature macro: FLOW_WRITER_COLLISION_EN - read the slot back first
// and refuse to overwrite a slot that already holds a different key.

`ifndef QUAD_BUS
`define QUAD_BUS 63:0
`endif
`ifndef BYTE_BUS
`define BYTE_BUS 7:0
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 15:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef HASH_BUS
`define HASH_BUS 7:0
`endif
`ifndef MAX_VAL_LEN
`define MAX_VAL_LEN 12
`endif

module flow_writer #(
  parameter int LOGIC_ENTRY_LEN  = 16,
  parameter int LOGIC_START_ADDR = 128
) (
  input  logic          clk,
  input  logic          rst,
  flow_writer_if.master bus
);

  typedef logic [`ADDR_BUS]                   addr_t;
  typedef logic [`DATA_BUS]                   data_t;
  typedef logic [`MAX_VAL_LEN-1:0][`BYTE_BUS] val_t;

  typedef enum logic [2:0] {
    FREE      = 3'd0,
    HASH      = 3'd1,
`ifdef FLOW_WRITER_COLLISION_EN
    CHECK     = 3'd2,
`endif
    WRITE_KEY = 3'd3,
    WRITE_VAL = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic [63:0] key_q, key_nxt, key_masked;
  val_t       val_q, val_nxt;
  logic [5:0] key_len_q, key_len_nxt;
  logic [5:0] val_len_q, val_len_nxt;
  addr_t      base_q, base_nxt;
  logic [5:0] cnt_q, cnt_nxt;
  logic       hash_start_q, hash_start_nxt;
  logic       error_q, error_nxt;
  logic       len_bad;
  logic [31:0] base_calc;

  logic       mem_ce, mem_we, ready;
  addr_t      mem_addr;
  logic [7:0] mem_byte;

`ifdef FLOW_WRITER_COLLISION_EN
  logic       collision_q, collision_nxt;
  logic       seen_nz_q, seen_nz_nxt;
  logic       seen_diff_q, seen_diff_nxt;
  logic       rd_nz, rd_diff;
`endif

  // Byte idx of a key, byte 0 being the most significant.
  function automatic logic [7:0] key_byte(input logic [63:0] k, input logic [5:0] idx);
    logic [63:0] s;
    s = k << (8 * idx[2:0]);
    return s[63:56];
  endfunction

  // State and datapath registers; reset drops everything back to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FREE;
      key_q        <= '0;
      val_q        <= '0;
      key_len_q    <= '0;
      val_len_q    <= '0;
      base_q       <= '0;
      cnt_q        <= '0;
      hash_start_q <= 1'b0;
      error_q      <= 1'b0;
`ifdef FLOW_WRITER_COLLISION_EN
      collision_q  <= 1'b0;
      seen_nz_q    <= 1'b0;
      seen_diff_q  <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      key_q        <= key_nxt;
      val_q        <= val_nxt;
      key_len_q    <= key_len_nxt;
      val_len_q    <= val_len_nxt;
      base_q       <= base_nxt;
      cnt_q        <= cnt_nxt;
      hash_start_q <= hash_start_nxt;
      error_q      <= error_nxt;
`ifdef FLOW_WRITER_COLLISION_EN
      collision_q  <= collision_nxt;
      seen_nz_q    <= seen_nz_nxt;
      seen_diff_q  <= seen_diff_nxt;
`endif
    end
  end

  // Next-state, datapath updates and memory-port drive for the current state.
  always_comb begin
    state_nxt      = state;
    key_nxt        = key_q;
    val_nxt        = val_q;
    key_len_nxt    = key_len_q;
    val_len_nxt    = val_len_q;
    base_nxt       = base_q;
    cnt_nxt        = cnt_q;
    hash_start_nxt = hash_start_q;
    error_nxt      = error_q;
    mem_ce         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_byte       = '0;
    ready          = 1'b0;
    key_masked     = '0;
`ifdef FLOW_WRITER_COLLISION_EN
    collision_nxt  = collision_q;
    seen_nz_nxt    = seen_nz_q;
    seen_diff_nxt  = seen_diff_q;
    rd_nz          = 1'b0;
    rd_diff        = 1'b0;
`endif

    for (int i = 0; i < 8; i++) begin
      if (i < int'(bus.key_len_i)) begin
        key_masked[63-8*i -: 8] = bus.key_i[63-8*i -: 8];
      end
    end

    len_bad = (bus.key_len_i == 6'd0) || (bus.key_len_i > 6'd8) ||
              (bus.val_len_i > 6'(`MAX_VAL_LEN)) ||
              ((7'(bus.key_len_i) + 7'(bus.val_len_i)) > 7'(LOGIC_ENTRY_LEN));

    base_calc = 32'(LOGIC_START_ADDR) + 32'(bus.hash_val) * 32'(LOGIC_ENTRY_LEN);

    case (state)
      FREE: begin
        if (bus.start_i) begin
          key_nxt     = key_masked;
          val_nxt     = bus.flow_val_i;
          key_len_nxt = bus.key_len_i;
          val_len_nxt = bus.val_len_i;
          if (len_bad) begin
            error_nxt = 1'b1;
            state_nxt = DONE;
          end else begin
            hash_start_nxt = 1'b1;
            state_nxt      = HASH;
          end
        end
      end

      HASH: begin
        if (bus.hash_ready) begin
          hash_start_nxt = 1'b0;
          base_nxt       = addr_t'(base_calc);
          cnt_nxt        = '0;
`ifdef FLOW_WRITER_COLLISION_EN
          seen_nz_nxt    = 1'b0;
          seen_diff_nxt  = 1'b0;
          state_nxt      = CHECK;
`else
          state_nxt      = WRITE_KEY;
`endif
        end
      end

`ifdef FLOW_WRITER_COLLISION_EN
      CHECK: begin
        mem_ce        = 1'b1;
        mem_addr      = base_q + addr_t'(cnt_q);
        rd_nz         = seen_nz_q | (bus.mem_data_i[7:0] != 8'd0);
        rd_diff       = seen_diff_q | (bus.mem_data_i[7:0] != key_byte(key_q, cnt_q));
        seen_nz_nxt   = rd_nz;
        seen_diff_nxt = rd_diff;
        if (cnt_q == key_len_q - 6'd1) begin
          cnt_nxt = '0;
          if (rd_nz && rd_diff) begin
            collision_nxt = 1'b1;
            state_nxt     = DONE;
          end else begin
            state_nxt     = WRITE_KEY;
          end
        end else begin
          cnt_nxt = cnt_q + 6'd1;
        end
      end
`endif

      WRITE_KEY: begin
        mem_ce   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = base_q + addr_t'(cnt_q);
        mem_byte = key_byte(key_q, cnt_q);
        if (cnt_q == key_len_q - 6'd1) begin
          cnt_nxt   = '0;
          state_nxt = (val_len_q == 6'd0) ? DONE : WRITE_VAL;
        end else begin
          cnt_nxt = cnt_q + 6'd1;
        end
      end

      WRITE_VAL: begin
        mem_ce   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = base_q + addr_t'(key_len_q) + addr_t'(cnt_q);
        mem_byte = val_q[cnt_q[3:0]];
        if (cnt_q == val_len_q - 6'd1) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt_q + 6'd1;
        end
      end

      DONE: begin
        ready = 1'b1;
        if (!bus.start_i) begin
          error_nxt = 1'b0;
`ifdef FLOW_WRITER_COLLISION_EN
          collision_nxt = 1'b0;
`endif
          state_nxt = FREE;
        end
      end

      default: state_nxt = FREE;
    endcase
  end

  assign bus.mem_ce_o    = mem_ce;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_width_o = 4'd1;
  assign bus.mem_data_o  = data_t'(mem_byte);
  assign bus.ready_o     = ready;
  assign bus.error_o     = error_q;
  assign bus.hash_start  = hash_start_q;
  assign bus.hash_key    = key_q;
`ifdef FLOW_WRITER_COLLISION_EN
  assign bus.collision_o = collision_q;
`else
  assign bus.collision_o = 1'b0;
`endif

endmodule
